// File: rtl/l2_cacheline_adaptor.sv
// Bridges the L2's single-transaction 256-bit line port onto a 4-beat 64-bit memory burst.
// One request is latched in IDLE; a one-cycle line-level response is returned from DONE.
module l2_cacheline_adaptor #(
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned BURST_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [31:0]            address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [31:0]            address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int unsigned BEATS      = LINE_WIDTH / BURST_WIDTH;
  localparam int unsigned CNT_W      = $clog2(BEATS);
  localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
  localparam logic [31:0] ADDR_MASK  = ~32'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0] wline_q;
  logic [31:0]           addr_q;

  // State, beat counter, request latch and fill-line assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wline_q <= '0;
      addr_q  <= '0;
      line_o  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE) begin
        if (write_i) begin
          wline_q <= line_i;
          addr_q  <= address_i & ADDR_MASK;
        end else if (read_i) begin
          addr_q  <= address_i & ADDR_MASK;
        end
      end
      if (state_q == RD_BURST && resp_i)
        line_o[BURST_WIDTH*cnt_q +: BURST_WIDTH] <= burst_i;
    end
  end

  // Next-state and memory/L2 handshake decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    address_o = '0;
    burst_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (write_i)     state_d = WR_BURST;
        else if (read_i) state_d = RD_BURST;
      end
      RD_BURST: begin
        read_o    = 1'b1;
        address_o = addr_q;
        if (resp_i) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WR_BURST: begin
        write_o   = 1'b1;
        address_o = addr_q;
        burst_o   = wline_q[BURST_WIDTH*cnt_q +: BURST_WIDTH];
        if (resp_i) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        // L2 changes its request right after resp, so never sample here
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Directed self-checking bench for l2_cacheline_adaptor: reset, read/write bursts,
// gapped beats, eviction sequencing, request priority and mid-burst reset.
module tb_l2_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int errors = 0;
  int checks = 0;
  int resp_cnt = 0;
  bit overlap = 1'b0;

  l2_cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resp_o) resp_cnt++;
    if (read_o && write_o) overlap = 1'b1;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full gapless read: request in this IDLE cycle, beats on the next four, resp after
  task automatic run_read(input logic [31:0] addr, input logic [255:0] line, input string tag);
    read_i    = 1'b1;
    address_i = addr;
    tick();
    read_i    = 1'b0;
    address_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_read_o"}, read_o, 1);
      check({tag, "_write_o"}, write_o, 0);
      check({tag, "_addr"}, address_o, addr & 32'hFFFF_FFE0);
      check({tag, "_no_resp"}, resp_o, 0);
      resp_i  = 1'b1;
      burst_i = line[i*64 +: 64];
      tick();
    end
    resp_i  = 1'b0;
    burst_i = '0;
    check({tag, "_resp"}, resp_o, 1);
    check({tag, "_done_read_o"}, read_o, 0);
    check({tag, "_line"}, line_o, line);
  endtask

  localparam logic [255:0] RD_LINE = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] WR_LINE = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                      64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [255:0] RD2_LINE = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                       64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_1234_8765};

  initial begin
    int base;
    bit gap[6];
    int slice[6];
    gap   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    slice = '{0, 1, 1, 2, 3, 3};

    rst = 1'b1; read_i = 1'b1; write_i = 1'b0; resp_i = 1'b0;
    address_i = 32'h0000_1234; line_i = '0; burst_i = '0;
    tick(); tick();
    check("rst_resp_o", resp_o, 0);
    check("rst_read_o", read_o, 0);
    check("rst_write_o", write_o, 0);
    check("rst_address_o", address_o, 0);
    check("rst_burst_o", burst_o, 0);
    check("rst_line_o", line_o, 0);

    // Gapless read straight out of reset with read_i still high
    rst = 1'b0;
    run_read(32'h0000_1234, RD_LINE, "rd0");
    check("rd0_addr_exact", 32'h0000_1220, 32'h0000_1234 & 32'hFFFF_FFE0);
    tick();
    check("rd0_resp_pulse", resp_o, 0);
    check("rd0_line_hold", line_o, RD_LINE);

    // Write with gaps in resp_i; line_i changes after latch
    write_i = 1'b1; address_i = 32'h0000_ABCD; line_i = WR_LINE;
    tick();
    write_i = 1'b0; line_i = ~WR_LINE; address_i = 32'h0;
    for (int i = 0; i < 6; i++) begin
      check("wr_write_o", write_o, 1);
      check("wr_read_o", read_o, 0);
      check("wr_addr", address_o, 32'h0000_ABC0);
      check("wr_burst_o", burst_o, WR_LINE[slice[i]*64 +: 64]);
      check("wr_no_resp", resp_o, 0);
      resp_i  = gap[i];
      burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
    end
    resp_i = 1'b0;
    check("wr_resp", resp_o, 1);
    check("wr_done_write_o", write_o, 0);
    check("wr_line_o_untouched", line_o, RD_LINE);
    tick();
    check("wr_idle_burst_o", burst_o, 0);
    check("wr_idle_resp", resp_o, 0);

    // Eviction: write 0x100 then read 0x200 right after resp
    base = resp_cnt;
    write_i = 1'b1; address_i = 32'h0000_0100; line_i = RD2_LINE;
    tick();
    write_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("ev_wr_addr", address_o, 32'h0000_0100);
      check("ev_wr_burst", burst_o, RD2_LINE[i*64 +: 64]);
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    check("ev_wr_resp", resp_o, 1);
    tick();
    run_read(32'h0000_0200, WR_LINE, "ev_rd");
    tick();
    check("ev_resp_pulses", 32'(resp_cnt - base), 2);
    check("ev_no_overlap", overlap, 0);

    // Simultaneous read/write: write wins, read not serviced later
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_0300; line_i = WR_LINE;
    tick();
    read_i = 1'b0; write_i = 1'b0;
    check("both_write_o", write_o, 1);
    check("both_read_o", read_o, 0);
    resp_i = 1'b1;
    tick(); tick(); tick(); tick();
    check("both_resp", resp_o, 1);
    tick();
    resp_i = 1'b1;
    tick();
    resp_i = 1'b0;
    check("both_no_read", read_o, 0);
    check("idle_resp_ignored", resp_o, 0);
    check("idle_line_o", line_o, WR_LINE);

    // Reset after two read beats
    base = resp_cnt;
    read_i = 1'b1; address_i = 32'h0000_0400;
    tick();
    read_i = 1'b0;
    resp_i = 1'b1; burst_i = 64'h9999_9999_9999_9999;
    tick(); tick();
    resp_i = 1'b0; rst = 1'b1;
    tick();
    check("mrst_read_o", read_o, 0);
    check("mrst_write_o", write_o, 0);
    check("mrst_resp_o", resp_o, 0);
    check("mrst_address_o", address_o, 0);
    check("mrst_burst_o", burst_o, 0);
    check("mrst_line_o", line_o, 0);
    rst = 1'b0;
    run_read(32'h0000_0500, RD2_LINE, "post_rst");
    tick();
    check("mrst_resp_count", 32'(resp_cnt - base), 1);
    check("final_no_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2_cacheline_adaptor.md
Name: l2_cacheline_adaptor

Overview:
- Sits directly downstream of the L2 cache controller.
- Converts the L2's single-transaction 256-bit line interface (pmem_read/pmem_write/pmem_resp) into a 4-beat, 64-bit burst protocol toward physical memory / DRAM model.
- Latches one request, runs the burst, returns a single-cycle line-level response to the L2.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, memory beat width in bits.
- BEATS, LINE_WIDTH/BURST_WIDTH (4), beats per line; beat counter width is $clog2(BEATS).

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- line_i  input  LINE_WIDTH  write-back line from L2.
- line_o  output  LINE_WIDTH  fill line to L2.
- address_i  input  32  L2 line address.
- read_i  input  1  L2 pmem_read.
- write_i  input  1  L2 pmem_write.
- resp_o  output  1  L2 pmem_resp, one-cycle pulse.
- burst_i  input  BURST_WIDTH  read beat from memory.
- burst_o  output  BURST_WIDTH  write beat to memory.
- address_o  output  32  line-aligned memory address.
- read_o  output  1  memory burst read request.
- write_o  output  1  memory burst write request.
- resp_i  input  1  memory beat valid/accepted strobe.

Behaviour:
- Reset: state=IDLE, beat count=0, line_o=0, latched line/address=0.
  - All outputs are 0 after reset: resp_o, read_o, write_o, address_o, burst_o.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - If write_i, latch line_i, and latch address_i with low $clog2(LINE_WIDTH/8) bits (5) cleared; go to WR_BURST.
  - Else if read_i, latch the address the same way; go to RD_BURST.
  - write_i has priority if both are high. No memory request is driven in IDLE.
- RD_BURST:
  - read_o=1; address_o=latched address.
  - Each cycle resp_i=1: store burst_i into line_o slice [count*BURST_WIDTH +: BURST_WIDTH], then count++.
  - Beat 0 fills bits [63:0].
  - Cycles with resp_i=0 (gaps) hold the count and do not write line_o.
  - When resp_i=1 with count==BEATS-1: count goes to 0; next state is DONE.
- WR_BURST:
  - write_o=1; address_o=latched address; burst_o=latched line slice at current count (combinational from the count).
  - Each resp_i=1 means memory accepted that beat; count++.
  - Last beat: count goes to 0; next state is DONE.
- DONE:
  - resp_o=1 for exactly this one cycle; read_o=write_o=0.
  - Next state is always IDLE. Requests are not sampled in DONE.
  - This is required because the L2 drops or switches its request in the cycle after resp.
- Latency:
  - Read/write with gapless resp_i: request seen in IDLE cycle T; beats at T+1..T+4; resp_o at T+5.
  - Back-to-back write-then-read from the L2 (dirty eviction): read starts on the IDLE cycle after DONE, with no extra bubble.
- line_o holds its value from DONE until the next read's beats overwrite it. Writes never modify line_o.
- address_i and line_i may change after the IDLE latch cycle without effect.
- resp_i while in IDLE or DONE is ignored.
- read_i/write_i deasserting mid-burst is ignored; the burst always completes.
- rst mid-burst: returns to IDLE next edge with all outputs 0 and no resp_o. The memory model is reset with it.
- burst_o is 0 outside WR_BURST.

Test Plan:
- Reset: hold rst 2 cycles with read_i=1 -> all outputs 0; after release, read_o=1 the cycle after IDLE samples read_i.
- Gapless read:
  - Stimulus: address_i=0x0000_1234; beats 0x1111..., 0x2222..., 0x3333..., 0x4444... on consecutive resp_i.
  - Required: address_o=0x0000_1220; resp_o pulses 1 cycle at T+5; line_o={0x4444...,0x3333...,0x2222...,0x1111...}.
- Write with gaps:
  - Stimulus: line_i=256'h...DDDD_CCCC_BBBB_AAAA-style pattern; resp_i pattern 1,0,1,1,0,1.
  - Required: burst_o shows slice 0,1,1,2,3,3 on those cycles; write_o high throughout; resp_o one pulse after the 4th accepted beat; line_o unchanged.
- Eviction sequence:
  - Stimulus: write_i to 0x100, then the L2 asserts read_i to 0x200 the cycle after resp_o.
  - Required: write burst at 0x100, then read burst at 0x200; exactly 2 resp_o pulses; no overlap of read_o/write_o.
- Simultaneous read_i and write_i in IDLE -> write burst runs; read is not serviced until read_i is seen again in IDLE.
- Reset after 2 read beats -> next cycle all outputs 0, no resp_o; a new read afterward fills all 4 slices correctly.
